// File: rtl/detector_jogada_if.sv
// Signal bundle between the control unit / player switches and the play detector.
// The master side drives enable, clear and raw keys; the slave side returns the play.
interface detector_jogada_if;
    logic       habilita;
    logic       zera;
    logic [3:0] chaves;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic [3:0] db_estaveis;
    logic [3:0] db_estado;

    modport master (
        output habilita, zera, chaves,
        input  jogada, jogada_feita, jogada_invalida, db_estaveis, db_estado
    );

    modport slave (
        input  habilita, zera, chaves,
        output jogada, jogada_feita, jogada_invalida, db_estaveis, db_estado
    );
endinterface

// File: rtl/detector_jogada.sv
// Play detector: synchronises and debounces four player switches, accepts one
// single-key press per play and rejects zero/multi-key plays.
module detector_jogada #(
    parameter int DEB_CYCLES = 5
) (
    input logic              clock,
    input logic              reset,
    detector_jogada_if.slave bus
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [3:0] {
        INATIVO  = 4'd0,
        SOLTA    = 4'd1,
        AGUARDA  = 4'd2,
        AVALIA   = 4'd3,
        EMITE    = 4'd4,
        INVALIDA = 4'd5
    } state_t;

    logic [3:0]    s1_q, s2_q;
    logic [3:0]    estavel_q, estavel_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    jogada_q, jogada_d;
    state_t        state_q, state_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            estavel_q <= '0;
            jogada_q  <= '0;
            state_q   <= INATIVO;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            s1_q      <= bus.chaves;
            s2_q      <= s1_q;
            estavel_q <= estavel_d;
            jogada_q  <= jogada_d;
            state_q   <= state_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Each bit only flips after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        estavel_d = estavel_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != estavel_q[i]) begin
                if (cnt_q[i] == CNT_LAST) estavel_d[i] = s2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        jogada_d = jogada_q;
        case (state_q)
            INATIVO:  if (bus.habilita) state_d = SOLTA;
            SOLTA:    if (estavel_q == 4'd0) state_d = AGUARDA;
            AGUARDA:  if (estavel_q != 4'd0) state_d = AVALIA;
            AVALIA: begin
                if ($countones(estavel_q) == 1) begin
                    jogada_d = estavel_q;
                    state_d  = EMITE;
                end else begin
                    state_d  = INVALIDA;
                end
            end
            EMITE:    state_d = SOLTA;
            INVALIDA: state_d = SOLTA;
            default:  state_d = INATIVO;
        endcase
        // Losing the enable aborts any evaluation in flight, including its load.
        if (!bus.habilita) begin
            state_d  = INATIVO;
            jogada_d = jogada_q;
        end
        if (bus.zera) jogada_d = 4'd0;
    end

    assign bus.jogada          = jogada_q;
    assign bus.jogada_feita    = (state_q == EMITE);
    assign bus.jogada_invalida = (state_q == INVALIDA);
    assign bus.db_estaveis     = estavel_q;
    assign bus.db_estado       = state_q;
endmodule
